// File: rtl/nn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_layer_sequencer
// Description : Walks a DRAM table of 4-word layer descriptors, writes each
//               descriptor into the nn config registers, pulses start and
//               waits for nn to report the layer complete before moving on.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_layer_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic [ADDR_W-1:0] i_desc_base,
    input  logic [4:0]        i_num_layers,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_cfg,
    output logic [1:0]        o_cfg_addr,
    output logic              o_cfg_wr_en,
    output logic              o_start,
    input  logic              i_nn_done,
    output logic              o_busy,
    output logic              o_done,
    output logic [4:0]        o_layer_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Distance in words between consecutive layer descriptors.
    localparam logic [ADDR_W-1:0] LAYER_STRIDE = {{(ADDR_W-3){1'b0}}, 3'd4};

    state_t            state;
    logic [2:0]        cnt;          // load step within the current descriptor
    logic [ADDR_W-1:0] layer_base;   // word address of the current descriptor
    logic [4:0]        num_layers;   // latched layer count

    logic [2:0]        cnt_inc;
    logic [2:0]        cnt_dec;
    logic [ADDR_W-1:0] next_rd_addr;
    logic [ADDR_W-1:0] next_layer_base;

    // Outputs are registered, so every register is loaded with the value it
    // must show in the cycle after the current one. A read issued at step c
    // returns data at step c+1, which is registered and written at step c+2.
    assign cnt_inc         = cnt + 3'd1;
    assign cnt_dec         = cnt - 3'd1;
    assign next_rd_addr    = layer_base + {{(ADDR_W-3){1'b0}}, cnt_inc};
    assign next_layer_base = layer_base + LAYER_STRIDE;

    // Sequencer state machine with registered strobes and data outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            layer_base  <= '0;
            num_layers  <= 5'd0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_cfg       <= '0;
            o_cfg_addr  <= 2'd0;
            o_cfg_wr_en <= 1'b0;
            o_start     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_layer_idx <= 5'd0;
        end else begin
            // Strobes and their qualified data fall back to zero by default.
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_cfg       <= '0;
            o_cfg_addr  <= 2'd0;
            o_cfg_wr_en <= 1'b0;
            o_start     <= 1'b0;
            o_done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_go) begin
                        layer_base  <= i_desc_base;
                        num_layers  <= i_num_layers;
                        o_layer_idx <= 5'd0;
                        cnt         <= 3'd0;
                        if (i_num_layers == 5'd0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            o_busy    <= 1'b1;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= i_desc_base;
                        end
                    end
                end

                S_LOAD: begin
                    cnt <= cnt_inc;
                    // Steps 0..3 read; the first read is issued on entry.
                    if (cnt <= 3'd2) begin
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= next_rd_addr;
                    end
                    // Data from the read at step cnt-1 is present now.
                    if ((cnt >= 3'd1) && (cnt <= 3'd4)) begin
                        o_cfg_wr_en <= 1'b1;
                        o_cfg       <= i_rd_data;
                        o_cfg_addr  <= cnt_dec[1:0];
                    end
                    if (cnt == 3'd5) begin
                        state   <= S_START;
                        o_start <= 1'b1;
                    end
                end

                S_START: begin
                    // Any done pulse coinciding with start is ignored here.
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (i_nn_done) begin
                        if (o_layer_idx == (num_layers - 5'd1)) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            state       <= S_LOAD;
                            cnt         <= 3'd0;
                            o_layer_idx <= o_layer_idx + 5'd1;
                            layer_base  <= next_layer_base;
                            o_rd_en     <= 1'b1;
                            o_rd_addr   <= next_layer_base;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Upstream control stage for `nn`. Walks a table of per-layer configuration descriptors held in DRAM and programs `nn` one layer at a time:
- writes the four 16-bit config registers over the `nn` config bus;
- pulses start;
- waits for layer completion, then moves to the next layer.

It shares the DRAM read port with `nn`. Port ownership is granted externally: the sequencer reads only while `o_busy` is high and `nn` is not running a layer.

## Interface
- `ADDR_W`, 10, DRAM word-address width
- `DATA_W`, 16, DRAM and config word width
- `i_clk`  in  1  clock, all logic on rising edge
- `i_rst`  in  1  asynchronous active-low reset
- `i_go`  in  1  start a sequence; sampled only in IDLE
- `i_desc_base`  in  ADDR_W  word address of descriptor for layer 0; latched on accepted `i_go`
- `i_num_layers`  in  5  number of layers (0..31); latched on accepted `i_go`
- `o_rd_en`  out  1  DRAM read request
- `o_rd_addr`  out  ADDR_W  DRAM read address
- `i_rd_data`  in  DATA_W  DRAM read data, valid the cycle after `o_rd_en`
- `o_cfg`  out  DATA_W  config word to `nn`
- `o_cfg_addr`  out  2  config register index to `nn`
- `o_cfg_wr_en`  out  1  config write strobe to `nn`
- `o_start`  out  1  one-cycle layer start pulse to `nn`
- `i_nn_done`  in  1  one-cycle layer-complete pulse from `nn`
- `o_busy`  out  1  high from accepted `i_go` until sequence end
- `o_done`  out  1  one-cycle sequence-complete pulse
- `o_layer_idx`  out  5  index of layer currently being loaded or run

## Operation
- **Descriptor format:** layer L occupies 4 consecutive words at `base + 4*L`.
  - Word k is written to `nn` config register k (k = 0..3), in order 0,1,2,3.
- **Address arithmetic:** computed at ADDR_W bits and wraps modulo 2^ADDR_W. No error is flagged on wrap.
- **FSM states:** IDLE, LOAD, START, WAIT, DONE.
- **IDLE**
  - `i_go`=1 latches base/num and clears `layer_idx`.
  - If num=0, go to DONE; otherwise go to LOAD.
- **LOAD:** a 3-bit counter c runs 0..5.
  - For c=0..3: `o_rd_en`=1, `o_rd_addr` = base + 4*layer + c.
  - `i_rd_data` is registered into `o_cfg`. Result: for c=2..5, `o_cfg_wr_en`=1 and `o_cfg_addr`=c-2.
  - After c=5, go to START.
- **START:** `o_start`=1 for one cycle, then go to WAIT.
- **WAIT:** hold until `i_nn_done`=1.
  - If `layer_idx` = num-1, go to DONE.
  - Otherwise increment `layer_idx`, clear c, and go to LOAD.
- **DONE:** `o_done`=1 and `o_busy`=0 for one cycle, then go to IDLE.
- **Ignored inputs:**
  - `i_go` outside IDLE.
  - `i_nn_done` outside WAIT.
  - Changes to `i_desc_base`/`i_num_layers` after latch.
- **Idle values:** `o_cfg`, `o_cfg_addr` and `o_rd_addr` are held at 0 when their strobes are low.

## Timing
- **Reset:** `i_rst`=0 at any time (including mid-LOAD or WAIT) forces IDLE asynchronously.
  - All outputs go to 0, `o_layer_idx`=0, counter cleared.
  - No partial config write or start is issued after reset release.
- **Reference cycle:** cycle 0 is the cycle in which `i_go`=1 is sampled in IDLE.
- **Layer 0 load:**
  - `o_busy` rises in cycle 1.
  - Reads in cycles 1-4.
  - Config writes in cycles 3-6, register indices 0,1,2,3.
  - `o_start` in cycle 7.
  - WAIT from cycle 8.
- **Layer handoff:** `i_nn_done` in cycle n on a non-final layer gives:
  - first read of the next layer in cycle n+1;
  - its writes in n+3..n+6;
  - its `o_start` in n+7.
- **End of sequence:** `i_nn_done` in cycle n on the final layer gives `o_done`=1 and `o_busy`=0 in cycle n+1, and IDLE in cycle n+2.
  - A new `i_go` is accepted in cycle n+2 or later.
- **Zero layers:** num=0 gives `o_done` in cycle 1, with no reads and `o_busy` never high.
- **Strobe overlap:** `o_cfg_wr_en` and `o_start` are never high in the same cycle. `o_rd_en` is never high in WAIT.
- **Done on start edge:** an `i_nn_done` arriving in the same cycle as `o_start` is ignored, because the state is still START.

## Test plan
- **One layer:** base=64, num=1, DRAM[64..67]=0x0204,0x0201,0x0200,0x0040.
  - Expect reads at 64..67 in cycles 1-4.
  - Expect writes (addr,data) = (0,0x0204),(1,0x0201),(2,0x0200),(3,0x0040) in cycles 3-6.
  - Expect `o_start` in cycle 7.
  - Drive `i_nn_done` in cycle 12; expect `o_done` in cycle 13.
- **Three layers:** base=0, num=3.
  - Expect reads at 0-3, 4-7, 8-11.
  - Expect `o_layer_idx` 0,1,2.
  - Expect exactly 3 `o_start` pulses, each 7 cycles after the prior `i_nn_done`.
  - Expect one `o_done`.
- **Zero layers:** num=0 → `o_done` in cycle 1, no `o_rd_en`/`o_cfg_wr_en`/`o_start` ever.
- **Address wrap:** base=1022, num=1 → read addresses 1022,1023,0,1.
- **Ignored inputs:** pulse `i_go` and `i_nn_done` during LOAD → no restart, no early advance, write sequence unchanged.
- **Reset mid-load:** assert `i_rst`=0 in cycle 4 of a load.
  - Expect all outputs 0 immediately.
  - After release with no `i_go`: no `o_start`, `o_busy` stays 0.
